ser_tx: RTL and testbench

SER_TX -- requirements
Module: ser_tx

---
 rtl/ser_tx.sv | 99 +++++++++
 tb/tb_ser_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_tx.sv
// ser_tx: parallel-in, serial-out transmitter.
// A word accepted at a rising edge shows its first bit on sout in the next
// cycle. It then occupies exactly WIDTH cycles. A new word may be accepted
// on the last-bit cycle so that words follow each other with no gap.
module ser_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic             sout_reg,  sout_next;

    // Word rearranged so the first bit to send is always at the top.
    // This lets a single left-shift datapath serve both bit orders.
    logic [WIDTH-1:0] word_ordered;
    logic             last_bit;
    logic             accept;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign word_ordered[gi] = load_data[gi];
            end else begin : g_lsb
                assign word_ordered[gi] = load_data[WIDTH-1-gi];
            end
        end
    endgenerate

    assign last_bit   = (state_reg == SHIFT) && (count_reg == LAST);
    assign load_ready = (state_reg == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;
    assign busy       = (state_reg == SHIFT);
    assign sout_valid = (state_reg == SHIFT);
    assign word_done  = last_bit;
    assign sout       = sout_reg;

    // State register; reset is synchronous and overrides any load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            shreg_reg <= '0;
            sout_reg  <= IDLE_BIT;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            shreg_reg <= shreg_next;
            sout_reg  <= sout_next;
        end
    end

    // Next-state logic: load a word, advance one bit, or fall back to idle.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shreg_next = shreg_reg;
        sout_next  = sout_reg;
        if (accept) begin
            // The first bit goes straight to the output register. The rest
            // of the word waits in the shift register.
            state_next = SHIFT;
            count_next = '0;
            sout_next  = word_ordered[WIDTH-1];
            shreg_next = {word_ordered[WIDTH-2:0], 1'b0};
        end else if (last_bit) begin
            state_next = IDLE;
            count_next = '0;
            sout_next  = IDLE_BIT;
            shreg_next = '0;
        end else if (state_reg == SHIFT) begin
            count_next = count_reg + 1'b1;
            sout_next  = shreg_reg[WIDTH-1];
            shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx. Three instances share the same stimulus:
// u0 (MSB first, idle 0), u1 (LSB first, idle 0), u2 (MSB first, idle 1).
// A word-level model, tracking the bits still to send per instance, is
// checked against every output on every cycle. Directed literal checks
// pin the model.
module tb_ser_tx;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic [2:0]   ready_v, sout_v, valid_v, busy_v, done_v;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    bit msbf [3] = '{1'b1, 1'b0, 1'b1};
    bit idlb [3] = '{1'b0, 1'b0, 1'b1};

    ser_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_v[0]), .sout(sout_v[0]), .sout_valid(valid_v[0]),
        .busy(busy_v[0]), .word_done(done_v[0]));
    ser_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_v[1]), .sout(sout_v[1]), .sout_valid(valid_v[1]),
        .busy(busy_v[1]), .word_done(done_v[1]));
    ser_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u2 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_v[2]), .sout(sout_v[2]), .sout_valid(valid_v[2]),
        .busy(busy_v[2]), .word_done(done_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Word-level model: rem = bits of the current word still to appear
    // (including the one on sout now); mw = the word being sent.
    int         rem [3];
    logic [W-1:0] mw [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0;
            mw[i]  = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin
                    rem[i] = 0;
                end else begin
                    bit rdy;
                    rdy = (rem[i] <= 1);
                    if (rem[i] > 0) rem[i] = rem[i] - 1;
                    if (load_valid && rdy) begin
                        mw[i]  = load_data;
                        rem[i] = W;
                    end
                end
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                for (int i = 0; i < 3; i++) begin
                    logic es;
                    if (rem[i] > 0)
                        es = msbf[i] ? mw[i][rem[i]-1] : mw[i][W-rem[i]];
                    else
                        es = idlb[i];
                    chk($sformatf("sout[%0d]", i), 64'(sout_v[i]), 64'(es));
                    chk($sformatf("sout_valid[%0d]", i), 64'(valid_v[i]), 64'(rem[i] > 0));
                    chk($sformatf("busy[%0d]", i), 64'(busy_v[i]), 64'(rem[i] > 0));
                    chk($sformatf("word_done[%0d]", i), 64'(done_v[i]), 64'(rem[i] == 1));
                    chk($sformatf("load_ready[%0d]", i), 64'(ready_v[i]), 64'(rem[i] <= 1));
                end
            end
        end
    end

    // Recorder of the valid serial stream of each instance, first bit highest.
    logic [63:0] rec  [3];
    int          rcnt [3];
    int          wcnt [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rec[i] = '0; rcnt[i] = 0; wcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (valid_v[i] === 1'b1) begin
                    rec[i]  = {rec[i][62:0], sout_v[i]};
                    rcnt[i] = rcnt[i] + 1;
                end
                if (done_v[i] === 1'b1) wcnt[i] = wcnt[i] + 1;
            end
        end
    end

    task automatic clear_rec();
        for (int i = 0; i < 3; i++) begin
            rec[i] = '0; rcnt[i] = 0; wcnt[i] = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Occurrences of 1101 in a stream of len bits (first bit at len-1).
    function automatic int count_1101(input logic [63:0] v, input int len);
        int n = 0;
        logic [63:0] t;
        for (int i = len - 1; i >= 3; i--) begin
            t = v >> (i - 3);
            if (t[3:0] == 4'b1101) n++;
        end
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        tick(3);
        rst = 1'b1;
        check_en = 1'b1;
        chk("reset load_ready", 64'(ready_v), 64'(3'b111));
        chk("reset sout", 64'(sout_v), 64'(3'b100));
        chk("reset busy", 64'(busy_v), 64'(3'b000));

        // Long idle stretch: idle levels held, no word_done.
        clear_rec();
        tick(20);
        chk("idle word_done count", 64'(wcnt[0] + wcnt[1] + wcnt[2]), 64'd0);
        chk("idle sout", 64'(sout_v), 64'(3'b100));

        // Single word 8'hD0.
        clear_rec();
        load_data = 8'hD0; load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        tick(10);
        chk("D0 msb stream", rec[0], 64'hD0);
        chk("D0 msb bit count", 64'(rcnt[0]), 64'd8);
        chk("D0 word_done count", 64'(wcnt[0]), 64'd1);
        chk("D0 1101 detections", 64'(count_1101(rec[0], rcnt[0])), 64'd1);
        chk("D0 lsb stream", rec[1], 64'h0B);

        // LSB-first word 8'h0B.
        clear_rec();
        load_data = 8'h0B; load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        tick(10);
        chk("0B lsb stream", rec[1], 64'hD0);
        chk("0B lsb bit count", 64'(rcnt[1]), 64'd8);
        chk("0B lsb idle after", 64'({sout_v[1], valid_v[1]}), 64'd0);

        // Back-to-back A5 then 3C.
        clear_rec();
        load_data = 8'hA5; load_valid = 1'b1;
        tick(1);
        load_data = 8'h3C;
        tick(8);
        load_valid = 1'b0;
        tick(10);
        chk("b2b stream", rec[0], 64'hA53C);
        chk("b2b bit count", 64'(rcnt[0]), 64'd16);
        chk("b2b word_done count", 64'(wcnt[0]), 64'd2);

        // Reset after three bits of 8'hFF.
        clear_rec();
        load_data = 8'hFF; load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("abort sout", 64'(sout_v), 64'(3'b100));
        chk("abort valid", 64'(valid_v), 64'd0);
        chk("abort busy", 64'(busy_v), 64'd0);
        rst = 1'b1;
        tick(1);
        chk("abort ready", 64'(ready_v), 64'(3'b111));
        tick(10);
        chk("abort bit count", 64'(rcnt[0]), 64'd3);
        chk("abort stream", rec[0], 64'h7);

        // Request held from bit 2 of 8'h80; taken only on bit 8.
        clear_rec();
        load_data = 8'h80; load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        tick(1);
        load_data = 8'h11; load_valid = 1'b1;
        tick(5);
        chk("held ready bit7", 64'(ready_v[0]), 64'd0);
        tick(1);
        chk("held ready bit8", 64'(ready_v[0]), 64'd1);
        tick(1);
        load_valid = 1'b0;
        tick(10);
        chk("held stream", rec[0], 64'h8011);
        chk("held bit count", 64'(rcnt[0]), 64'd16);

        // Final idle stretch, including the idle-high instance.
        clear_rec();
        tick(20);
        chk("final idle word_done", 64'(wcnt[0] + wcnt[1] + wcnt[2]), 64'd0);
        chk("final idle sout", 64'(sout_v), 64'(3'b100));

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
